control_pipe_unit: RTL

//  Registered, handshaked successor to the combinational control_file decoder for the KGP RISC core.

---
 rtl/control_pipe_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/control_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_pipe_unit
// Brief    : Registered, handshaked control-word decoder for the KGP RISC core
//            with multi-cycle memory sequencing, flush and back-pressure.
// Revision : 1.0  initial release
// ============================================================================
module control_pipe_unit #(
    parameter int OP_W       = 6,
    parameter int FN_W       = 6,
    parameter int MEM_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] function_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      reg_dst,
    output logic            reg_write,
    output logic [1:0]      alu_imm,
    output logic            fn,
    output logic [2:0]      logic_fn,
    output logic            fn_class,
    output logic            data_read,
    output logic            data_write,
    output logic [1:0]      regin_data,
    output logic [2:0]      br_type,
    output logic [1:0]      pc_sel,
    output logic            illegal,
    output logic            illegal_err
);

    localparam int CNT_W = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MEM_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MEM   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t           state_q;
    logic [18:0]      word_q;
    logic             illegal_q;
    logic             illegal_err_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic [18:0]      word_d;
    logic             illegal_d;
    logic             hi_bits;
    logic             is_mem;
    logic             capture;

    // Control word layout, MSB first: RD RW AI FN LF FC DR DW RI BR PC
    assign hi_bits = ((opcode >> 6) != '0) || ((function_val >> 6) != '0);

    always_comb begin
        word_d    = '0;
        illegal_d = 1'b0;
        if (hi_bits) begin
            illegal_d = 1'b1;
        end else begin
            case (opcode[5:0])
                6'd0: begin
                    case (function_val[5:0])
                        6'd32:   word_d = 19'b01_1_00_0_000_0_0_0_00_000_00;
                        6'd34:   word_d = 19'b01_1_00_1_000_0_0_0_00_000_00;
                        6'd42:   word_d = 19'b01_1_00_1_000_0_0_0_01_000_00;
                        6'd36:   word_d = 19'b01_1_00_0_000_1_0_0_00_000_00;
                        6'd37:   word_d = 19'b01_1_00_0_001_1_0_0_00_000_00;
                        6'd38:   word_d = 19'b01_1_00_0_010_1_0_0_00_000_00;
                        6'd8:    word_d = 19'b00_0_00_0_000_0_0_0_00_000_10;
                        default: illegal_d = 1'b1;
                    endcase
                end
                6'd12:   word_d = 19'b00_1_01_0_000_0_0_0_00_000_00;
                6'd13:   word_d = 19'b00_1_01_0_000_1_0_0_00_000_00;
                6'd35:   word_d = 19'b00_1_01_0_000_0_1_0_10_000_00;
                6'd43:   word_d = 19'b00_0_01_0_000_0_0_1_00_000_00;
                6'd2:    word_d = 19'b00_0_00_0_000_0_0_0_00_000_01;
                6'd3:    word_d = 19'b10_1_00_0_000_0_0_0_11_000_01;
                6'd4:    word_d = 19'b00_0_00_1_000_0_0_0_00_001_11;
                6'd5:    word_d = 19'b00_0_00_1_000_0_0_0_00_010_11;
                default: illegal_d = 1'b1;
            endcase
        end
    end

    assign is_mem   = word_d[8] | word_d[7];
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_VALID) && out_ready);
    assign capture  = in_ready && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            word_q        <= '0;
            illegal_q     <= 1'b0;
            illegal_err_q <= 1'b0;
            out_valid_q   <= 1'b0;
            cnt_q         <= '0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else if (capture) begin
            word_q        <= word_d;
            illegal_q     <= illegal_d;
            illegal_err_q <= illegal_err_q | illegal_d;
            if (is_mem) begin
                state_q     <= S_MEM;
                cnt_q       <= C_CNT_LOAD;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= S_VALID;
                out_valid_q <= 1'b1;
            end
        end else begin
            case (state_q)
                S_MEM: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_VALID;
                        out_valid_q <= 1'b1;
                        word_q[8]   <= 1'b0;
                        word_q[7]   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_VALID: begin
                    // Only reached when no new instruction follows the accepted one
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        word_q      <= '0;
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign illegal     = illegal_q;
    assign illegal_err = illegal_err_q;
    assign reg_dst     = word_q[18:17];
    assign reg_write   = word_q[16];
    assign alu_imm     = word_q[15:14];
    assign fn          = word_q[13];
    assign logic_fn    = word_q[12:10];
    assign fn_class    = word_q[9];
    assign data_read   = word_q[8];
    assign data_write  = word_q[7];
    assign regin_data  = word_q[6:5];
    assign br_type     = word_q[4:2];
    assign pc_sel      = word_q[1:0];

endmodule
`default_nettype wire
